imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 42 ++++
 rtl/imem_loader_if.sv | 20 ++
 rtl/imem_loader_byte_packer.sv | 33 +++
 rtl/imem_loader.sv | 140 ++++++++++++++
 tb/tb_imem_loader.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM encoding, word geometry and
// the per-state registered status flags.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        LOAD,
        WRITE,
        CHECK,
        DONE,
        ERR
    } state_t;

    localparam int          WORD_BYTES = 4;
    localparam int          BCNT_W     = $clog2(WORD_BYTES);
    localparam logic [31:0] ADDR_STEP  = 32'd4;
    // The word count arrives as a single byte, so an 8-bit index never wraps.
    localparam int          IDX_W      = 8;

    typedef struct packed {
        logic rx_ready;
        logic wr_en;
        logic busy;
        logic done;
        logic error;
        logic cpu_hold;
    } flags_t;

    function automatic flags_t flags_for(input state_t s);
        flags_t f;
        case (s)
            LEN, LOAD, CHECK: f = '{rx_ready: 1'b1, wr_en: 1'b0, busy: 1'b1, done: 1'b0, error: 1'b0, cpu_hold: 1'b1};
            WRITE:            f = '{rx_ready: 1'b0, wr_en: 1'b1, busy: 1'b1, done: 1'b0, error: 1'b0, cpu_hold: 1'b1};
            DONE:             f = '{rx_ready: 1'b0, wr_en: 1'b0, busy: 1'b0, done: 1'b1, error: 1'b0, cpu_hold: 1'b0};
            ERR:              f = '{rx_ready: 1'b0, wr_en: 1'b0, busy: 1'b0, done: 1'b0, error: 1'b1, cpu_hold: 1'b1};
            default:          f = '{rx_ready: 1'b0, wr_en: 1'b0, busy: 1'b0, done: 1'b0, error: 1'b0, cpu_hold: 1'b1};
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles little-endian bytes into a 32-bit word (first byte -> bits 7:0).
// last_byte flags that the next shifted byte completes the word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last_byte
);

    logic [BCNT_W-1:0] count;

    assign last_byte = (count == BCNT_W'(WORD_BYTES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            word  <= '0;
        end else if (clear) begin
            count <= '0;
            word  <= '0;
        end else if (shift) begin
            // Shifting right leaves the earliest byte in the low lane after four shifts.
            word  <= {byte_in, word[31:8]};
            count <= last_byte ? '0 : count + BCNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte image into instruction memory while holding the CPU.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MAX_WORDS = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error
);

    state_t           state;
    flags_t           flags;
    logic [IDX_W-1:0] index;
    logic [IDX_W-1:0] n_words;
    logic [31:0]      word;
    logic             accept;
    logic             shift;
    logic             clear;
    logic             last_byte;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       sum;
`endif

    assign accept = bus.rx_valid && flags.rx_ready;
    assign shift  = accept && (state == LOAD);
    assign clear  = start && (state == IDLE || state == DONE || state == ERR);

    assign bus.rx_ready = flags.rx_ready;
    assign bus.wr_en    = flags.wr_en;
    assign bus.wr_data  = word;
    assign busy         = flags.busy;
    assign done         = flags.done;
    assign error        = flags.error;
    assign cpu_hold     = flags.cpu_hold;

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .shift     (shift),
        .byte_in   (bus.rx_data),
        .word      (word),
        .last_byte (last_byte)
    );

    // Flags are registered alongside the state so every output is glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            flags       <= flags_for(IDLE);
            index       <= '0;
            n_words     <= '0;
            bus.wr_addr <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
            sum         <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state <= LEN;
                        flags <= flags_for(LEN);
                    end
                end
                LEN: begin
                    if (accept) begin
                        n_words <= bus.rx_data;
                        index   <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum     <= bus.rx_data;
`endif
                        if (bus.rx_data == 8'd0) begin
                            state <= DONE;
                            flags <= flags_for(DONE);
                        end else if (int'(bus.rx_data) > MAX_WORDS) begin
                            state <= ERR;
                            flags <= flags_for(ERR);
                        end else begin
                            state <= LOAD;
                            flags <= flags_for(LOAD);
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                        sum <= sum + bus.rx_data;
`endif
                        if (last_byte) begin
                            state       <= WRITE;
                            flags       <= flags_for(WRITE);
                            bus.wr_addr <= BASE_ADDR + ADDR_STEP * 32'(index);
                        end
                    end
                end
                WRITE: begin
                    index <= index + IDX_W'(1);
                    if (index + IDX_W'(1) == n_words) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= CHECK;
                        flags <= flags_for(CHECK);
`else
                        state <= DONE;
                        flags <= flags_for(DONE);
`endif
                    end else begin
                        state <= LOAD;
                        flags <= flags_for(LOAD);
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        if (sum + bus.rx_data == 8'd0) begin
                            state <= DONE;
                            flags <= flags_for(DONE);
                        end else begin
                            state <= ERR;
                            flags <= flags_for(ERR);
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    flags <= flags_for(IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized sessions for imem_loader, checked against a word-list model of the load.
module tb_imem_loader;

    localparam int          MAX_W = 64;
    localparam logic [31:0] BASE  = 32'h0;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_hold;
    logic busy;
    logic done;
    logic error;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [63:0] wq[$];

    imem_loader_if bus ();

    imem_loader #(.MAX_WORDS(MAX_W), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) wq.push_back({bus.wr_addr, bus.wr_data});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ":rx_ready"}, 64'(bus.rx_ready), 64'(0));
        check({tag, ":wr_en"},    64'(bus.wr_en),    64'(0));
        check({tag, ":wr_addr"},  64'(bus.wr_addr),  64'(BASE));
        check({tag, ":wr_data"},  64'(bus.wr_data),  64'(0));
        check({tag, ":flags"},    64'({busy, done, error, cpu_hold}), 64'(4'b0001));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte after 'gap' idle cycles and returns just after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap, inout int timeouts);
        int t;
        repeat (gap) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
        end
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        t = 0;
        while (bus.rx_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) timeouts++;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    // gap < 0 picks a random 0..2 idle cycles per byte; poke pulses start mid-load.
    task automatic run_session(input string tag, input int n, input logic [7:0] d[$],
                               input int gap, input bit bad_ck, input bit poke);
        logic [63:0] exp_w[$];
        logic [7:0]  sum;
        bit          exp_err;
        int          to;
        int          t;
        to = 0;
        wq.delete();
        exp_err = (n > MAX_W);
        sum = 8'(n);
        if (!exp_err)
            for (int i = 0; i < n; i++)
                exp_w.push_back({BASE + 32'(4 * i), d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]});
        foreach (d[i]) sum += d[i];

        pulse_start();
        check({tag, ":busy_hold_after_start"}, 64'({busy, cpu_hold, done, error}), 64'(4'b1100));
        send_byte(8'(n), 0, to);
        if (!exp_err && n > 0) begin
            foreach (d[i]) begin
                send_byte(d[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap, to);
                if (poke && i == 1) pulse_start();
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(bad_ck ? (8'h00 - sum + 8'h01) : (8'h00 - sum), 0, to);
            if (bad_ck) exp_err = 1'b1;
`endif
        end
        go_idle();
        t = 0;
        while (busy !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, ":rx_timeouts"}, 64'(to), 64'(0));
        check({tag, ":busy_timeout"}, 64'(t >= 200), 64'(0));
        check({tag, ":status"}, 64'({busy, done, error, cpu_hold}),
              exp_err ? 64'(4'b0011) : 64'(4'b0100));
        check({tag, ":n_writes"}, 64'(wq.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size(); i++)
            check($sformatf("%s:w%0d", tag, i), (i < wq.size()) ? wq[i] : 64'hx, exp_w[i]);
    endtask

    initial begin
        logic [7:0] d[$];
        int         to;
        int         n;

        to = 0;
        reset = 1'b1;
        start = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("idle_no_start");

        // Two words from a real instruction stream, with explicit expected words.
        d = '{8'h13, 8'h05, 8'h80, 8'h00, 8'h93, 8'h0A, 8'h35, 8'h00};
        run_session("two_words", 2, d, 0, 1'b0, 1'b0);
        check("two_words:w0_const", (wq.size() > 0) ? wq[0] : 64'hx, {32'h0, 32'h00800513});
        check("two_words:w1_const", (wq.size() > 1) ? wq[1] : 64'hx, {32'h4, 32'h00350A93});

        // Zero-length image completes on the edge that accepts the count.
        d.delete();
        wq.delete();
        pulse_start();
        send_byte(8'd0, 0, to);
        check("zero_len:done_next_edge", 64'({done, cpu_hold, busy}), 64'(3'b100));
        go_idle();
        check("zero_len:no_write", 64'(wq.size()), 64'(0));

        // Oversized count errors out, then a normal session recovers.
        run_session("too_long", MAX_W + 1, d, 0, 1'b0, 1'b0);
        d = '{8'h13, 8'h00, 8'h00, 8'h00};
        run_session("recover", 1, d, 0, 1'b0, 1'b0);

        // Alternating valid gaps with a stray start mid-load.
        run_session("gapped", 1, d, 1, 1'b0, 1'b1);

`ifdef LOADER_CHECKSUM_EN
        run_session("ck_good", 1, d, 0, 1'b0, 1'b0);
        run_session("ck_bad", 1, d, 0, 1'b1, 1'b0);
`endif

        // Reset after six data bytes of a three-word image.
        wq.delete();
        pulse_start();
        send_byte(8'd3, 0, to);
        for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), 0, to);
        go_idle();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset:rx_timeouts", 64'(to), 64'(0));
        check("mid_reset:n_writes", 64'(wq.size()), 64'(1));
        check("mid_reset:w0", (wq.size() > 0) ? wq[0] : 64'hx, {32'h0, 32'hA3A2A1A0});

        // Randomized sessions.
        for (int s = 0; s < 8; s++) begin
            n = int'($urandom_range(1, 6));
            d.delete();
            for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
            run_session($sformatf("rand%0d", s), n, d, -1, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
